// File: rtl/picnic_pkg.sv
// ============================================================================
// picnic_pkg: shared widths, FSM encodings and stream selects. Rev 1.0
// ============================================================================
`default_nettype none

package picnic_pkg;

    localparam int W_COMMIT = 256;
    localparam int RIDX_W   = 8;
    localparam int BEAT_W   = 9;

    typedef logic [2:0] rcc_state_t;

    localparam rcc_state_t ST_IDLE    = 3'd0;
    localparam rcc_state_t ST_LAUNCH  = 3'd1;
    localparam rcc_state_t ST_RELEASE = 3'd2;
    localparam rcc_state_t ST_NEXT    = 3'd3;
    localparam rcc_state_t ST_STREAM  = 3'd4;
    localparam rcc_state_t ST_FINISH  = 3'd5;

    localparam logic SEL_CH = 1'b0;
    localparam logic SEL_CN = 1'b1;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/commit_buf.sv
// ============================================================================
// commit_buf: dual Ch/Cn register file, written per round, read per beat. Rev 1.0
// ============================================================================
`default_nettype none

module commit_buf
    import picnic_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = W_COMMIT,
    parameter int AW    = idx_w(DEPTH)
)
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [W-1:0]      wr_ch,
    input  logic [W-1:0]      wr_cn,
    input  logic [BEAT_W-1:0] rd_beat,
    output logic [W-1:0]      rd_data,
    output logic              rd_sel
);

    logic [W-1:0]  ch_mem [DEPTH];
    logic [W-1:0]  cn_mem [DEPTH];
    logic [AW-1:0] rd_idx;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ch_mem[wr_idx] <= wr_ch;
            cn_mem[wr_idx] <= wr_cn;
        end
    end

    // Beats 0..DEPTH-1 map to Ch entries, the rest to Cn entries.
    always_comb begin
        rd_sel  = (rd_beat >= BEAT_W'(DEPTH)) ? SEL_CN : SEL_CH;
        rd_idx  = (rd_sel == SEL_CN) ? AW'(rd_beat - BEAT_W'(DEPTH)) : AW'(rd_beat);
        rd_data = (rd_sel == SEL_CN) ? cn_mem[rd_idx] : ch_mem[rd_idx];
    end

endmodule

`default_nettype wire

// File: rtl/round_commit_collector.sv
// ============================================================================
// round_commit_collector: runs the per-round stage T_ROUNDS times, then streams Ch/Cn. Rev 1.0
// ============================================================================
`default_nettype none

module round_commit_collector
    import picnic_pkg::*;
#(
    parameter int T_ROUNDS = 16,
    parameter int W        = W_COMMIT
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RIDX_W-1:0] j_in,
    output logic              busy,
    output logic              done,
    output logic              rf_start,
    output logic [RIDX_W-1:0] rf_t,
    output logic [RIDX_W-1:0] rf_j,
    input  logic [W-1:0]      rf_ch,
    input  logic [W-1:0]      rf_cn,
    input  logic              rf_end,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic              out_sel,
    output logic              out_last
);

    localparam int                AW         = idx_w(T_ROUNDS);
    localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(T_ROUNDS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(2 * T_ROUNDS - 1);

    rcc_state_t        state;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] rd_beat;
    logic              cap_en;
    logic [W-1:0]      rd_data;
    logic              rd_sel;

    assign cap_en  = (state == ST_LAUNCH) && rf_end;
    // Read address runs one beat ahead so the next word is ready at transfer time.
    assign rd_beat = (state == ST_STREAM) ? (beat + BEAT_W'(1)) : '0;

    commit_buf #(
        .DEPTH (T_ROUNDS),
        .W     (W),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (cap_en),
        .wr_idx  (AW'(rf_t)),
        .wr_ch   (rf_ch),
        .wr_cn   (rf_cn),
        .rd_beat (rd_beat),
        .rd_data (rd_data),
        .rd_sel  (rd_sel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            beat      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_start  <= 1'b0;
            rf_t      <= '0;
            rf_j      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rf_j     <= j_in;
                        rf_t     <= '0;
                        busy     <= 1'b1;
                        rf_start <= 1'b1;
                        state    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (rf_end) begin
                        rf_start <= 1'b0;
                        state    <= ST_RELEASE;
                    end
                end
                // Hold off the next launch until the upstream end level clears.
                ST_RELEASE: begin
                    if (!rf_end) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (rf_t == LAST_ROUND) begin
                        beat      <= '0;
                        out_valid <= 1'b1;
                        out_data  <= rd_data;
                        out_sel   <= rd_sel;
                        out_last  <= (LAST_BEAT == '0);
                        state     <= ST_STREAM;
                    end else begin
                        rf_t     <= rf_t + RIDX_W'(1);
                        rf_start <= 1'b1;
                        state    <= ST_LAUNCH;
                    end
                end
                ST_STREAM: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_FINISH;
                        end else begin
                            beat     <= rd_beat;
                            out_data <= rd_data;
                            out_sel  <= rd_sel;
                            out_last <= (rd_beat == LAST_BEAT);
                        end
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_round_commit_collector.sv
// ============================================================================
// tb_round_commit_collector: directed bench for the T_ROUNDS=4 and T_ROUNDS=1 builds. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_round_commit_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b0;

    logic         start = 1'b0;
    logic [7:0]   j_in = 8'h00;
    logic         busy, done, rf_start, rf_end;
    logic [7:0]   rf_t, rf_j;
    logic [255:0] rf_ch, rf_cn, out_data;
    logic         out_valid, out_sel, out_last;
    logic         out_ready = 1'b1;

    logic         d1_start = 1'b0;
    logic [7:0]   d1_j_in = 8'h00;
    logic         d1_busy, d1_done, d1_rf_start, d1_rf_end;
    logic [7:0]   d1_rf_t, d1_rf_j;
    logic [255:0] d1_rf_ch, d1_rf_cn, d1_out_data;
    logic         d1_out_valid, d1_out_sel, d1_out_last;
    logic         d1_out_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    round_commit_collector #(.T_ROUNDS(4), .W(256)) dut (
        .clk(clk), .reset(reset), .start(start), .j_in(j_in),
        .busy(busy), .done(done), .rf_start(rf_start), .rf_t(rf_t), .rf_j(rf_j),
        .rf_ch(rf_ch), .rf_cn(rf_cn), .rf_end(rf_end),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .out_last(out_last)
    );

    round_commit_collector #(.T_ROUNDS(1), .W(256)) dut1 (
        .clk(clk), .reset(reset), .start(d1_start), .j_in(d1_j_in),
        .busy(d1_busy), .done(d1_done), .rf_start(d1_rf_start), .rf_t(d1_rf_t), .rf_j(d1_rf_j),
        .rf_ch(d1_rf_ch), .rf_cn(d1_rf_cn), .rf_end(d1_rf_end),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
        .out_sel(d1_out_sel), .out_last(d1_out_last)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mock upstream stage: end rises 5 cycles after start, then lingers sticky_cyc cycles.
    int sticky_cyc = 0;
    int m_cnt, m_hold, m1_cnt;
    assign rf_ch    = 256'hC0 + 256'(rf_t);
    assign rf_cn    = 256'hA0 + 256'(rf_t);
    assign d1_rf_ch = 256'hC0 + 256'(d1_rf_t);
    assign d1_rf_cn = 256'hA0 + 256'(d1_rf_t);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_end <= 1'b0; m_cnt <= 0; m_hold <= 0;
        end else if (rf_start && !rf_end) begin
            if (m_cnt == 4) begin rf_end <= 1'b1; m_cnt <= 0; end
            else m_cnt <= m_cnt + 1;
        end else if (!rf_start && rf_end) begin
            if (m_hold >= sticky_cyc) begin rf_end <= 1'b0; m_hold <= 0; end
            else m_hold <= m_hold + 1;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            d1_rf_end <= 1'b0; m1_cnt <= 0;
        end else if (d1_rf_start && !d1_rf_end) begin
            if (m1_cnt == 1) begin d1_rf_end <= 1'b1; m1_cnt <= 0; end
            else m1_cnt <= m1_cnt + 1;
        end else if (!d1_rf_start && d1_rf_end) begin
            d1_rf_end <= 1'b0;
        end
    end

    logic bp_mode = 1'b0;
    int   rp = 0;
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            out_ready = (rp == 0) || (rp == 3);
            rp = (rp + 1) % 4;
        end else begin
            out_ready = 1'b1;
            rp = 0;
        end
    end

    int           n_launch, n_beat, n_done;
    logic [7:0]   l_t [16];
    logic [7:0]   l_j [16];
    logic [255:0] b_data [16];
    logic         b_sel [16];
    logic         b_last [16];
    logic         prev_rfs = 1'b0, prev_stall = 1'b0, prev_xlast = 1'b0;
    logic [255:0] p_data;
    logic         p_sel, p_last;

    always @(negedge clk) begin
        if (reset) begin
            if (rf_start && !prev_rfs) begin
                if (n_launch < 16) begin l_t[n_launch] = rf_t; l_j[n_launch] = rf_j; end
                n_launch++;
            end
            if (prev_stall) begin
                check("hold_valid", 256'(out_valid), 256'd1);
                check("hold_data", out_data, p_data);
                check("hold_sel", 256'(out_sel), 256'(p_sel));
                check("hold_last", 256'(out_last), 256'(p_last));
            end
            if (done) begin
                check("done_after_last", 256'(prev_xlast), 256'd1);
                check("busy_low_at_done", 256'(busy), 256'd0);
                n_done++;
            end
            prev_xlast = out_valid && out_ready && out_last;
            if (out_valid && out_ready) begin
                if (n_beat < 16) begin
                    b_data[n_beat] = out_data; b_sel[n_beat] = out_sel; b_last[n_beat] = out_last;
                end
                n_beat++;
            end
            prev_stall = out_valid && !out_ready;
            p_data = out_data; p_sel = out_sel; p_last = out_last;
        end else begin
            prev_stall = 1'b0;
            prev_xlast = 1'b0;
        end
        prev_rfs = rf_start;
    end

    task automatic clear_mon();
        n_launch = 0; n_beat = 0; n_done = 0;
    endtask

    task automatic run4(input logic [7:0] j, input logic bp, input int sticky, input logic mid);
        bit pulsed = 1'b0;
        int cyc = 0;
        clear_mon();
        bp_mode = bp;
        sticky_cyc = sticky;
        @(negedge clk); j_in = j; start = 1'b1;
        @(negedge clk); start = 1'b0; j_in = 8'h00;
        check("busy_after_start", 256'(busy), 256'd1);
        check("rf_t_first", 256'(rf_t), 256'd0);
        while (n_done == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (mid && !pulsed && rf_start && rf_t == 8'd2) begin
                start = 1'b1; j_in = 8'h77; pulsed = 1'b1;
            end else begin
                start = 1'b0; j_in = 8'h00;
            end
        end
        start = 1'b0;
        check("run_timeout", 256'(n_done > 0), 256'd1);
        check("rf_j_kept", 256'(rf_j), 256'(j));
        check("launch_count", 256'(n_launch), 256'd4);
        for (int t = 0; t < 4; t++) begin
            check("launch_rf_t", 256'(l_t[t]), 256'(t));
            check("launch_rf_j", 256'(l_j[t]), 256'(j));
        end
        check("beat_count", 256'(n_beat), 256'd8);
        for (int k = 0; k < 8; k++) begin
            check("beat_data", b_data[k], (k < 4) ? 256'hC0 + 256'(k) : 256'hA0 + 256'(k - 4));
            check("beat_sel", 256'(b_sel[k]), 256'(k >= 4));
            check("beat_last", 256'(b_last[k]), 256'(k == 7));
        end
        @(negedge clk);
        check("done_one_cycle", 256'(done), 256'd0);
        check("idle_busy", 256'(busy), 256'd0);
        bp_mode = 1'b0;
    endtask

    initial begin
        int cyc;
        int nb;
        bit got_done;
        bit prev_l;
        logic [255:0] d1d [2];
        logic d1s [2];
        logic d1l [2];

        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_rf_start", 256'(rf_start), 256'd0);
        check("rst_out_valid", 256'(out_valid), 256'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_done", 256'(done), 256'd0);
        check("idle_rf_t", 256'(rf_t), 256'd0);
        check("idle_rf_j", 256'(rf_j), 256'd0);
        check("idle_out_data", out_data, 256'd0);
        check("idle_out_last", 256'(out_last), 256'd0);

        run4(8'h05, 1'b0, 0, 1'b0);
        run4(8'h05, 1'b1, 0, 1'b0);
        run4(8'h05, 1'b0, 10, 1'b0);
        run4(8'h05, 1'b0, 0, 1'b1);

        // Abandon a run while round 1 is launched.
        clear_mon();
        @(negedge clk); j_in = 8'h05; start = 1'b1;
        @(negedge clk); start = 1'b0; j_in = 8'h00;
        cyc = 0;
        while (!(rf_start && rf_t == 8'd1) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_round1", 256'(rf_t), 256'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_rf_start", 256'(rf_start), 256'd0);
        check("midrst_busy", 256'(busy), 256'd0);
        check("midrst_out_valid", 256'(out_valid), 256'd0);
        check("midrst_rf_t", 256'(rf_t), 256'd0);
        @(negedge clk); reset = 1'b1;
        run4(8'h05, 1'b0, 0, 1'b0);

        // Single-round build: exactly Ch0 then Cn0.
        @(negedge clk); d1_j_in = 8'h09; d1_start = 1'b1;
        @(negedge clk); d1_start = 1'b0;
        cyc = 0; nb = 0; got_done = 1'b0; prev_l = 1'b0;
        while (!got_done && cyc < 500) begin
            if (d1_done) begin
                check("d1_done_after_last", 256'(prev_l), 256'd1);
                got_done = 1'b1;
            end
            prev_l = d1_out_valid && d1_out_last;
            if (d1_out_valid) begin
                if (nb < 2) begin d1d[nb] = d1_out_data; d1s[nb] = d1_out_sel; d1l[nb] = d1_out_last; end
                nb++;
            end
            @(negedge clk);
            cyc++;
        end
        check("d1_done_seen", 256'(got_done), 256'd1);
        check("d1_beat_count", 256'(nb), 256'd2);
        check("d1_beat0_data", d1d[0], 256'hC0);
        check("d1_beat0_sel", 256'(d1s[0]), 256'd0);
        check("d1_beat0_last", 256'(d1l[0]), 256'd0);
        check("d1_beat1_data", d1d[1], 256'hA0);
        check("d1_beat1_sel", 256'(d1s[1]), 256'd1);
        check("d1_beat1_last", 256'(d1l[1]), 256'd1);
        check("d1_rf_j", 256'(d1_rf_j), 256'h09);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
